// File: rtl/mux_16_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for the 16-lane arbiter.
package arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // First set request bit scanning upward from ptr, wrapping past lane 15.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_16_rr_arbiter_if.sv
// Lane-side and consumer-side signals of the 16-lane round-robin arbiter.
interface mux_16_rr_arbiter_if #(parameter int BUS = 4);
  import arb_pkg::*;

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*BUS-1:0] data_in;
  logic                   out_ready;
  logic [NUM_REQ-1:0]     gnt;
  logic [SEL_W-1:0]       selector;
  logic [BUS-1:0]         out_data;
  logic                   out_valid;
  logic [NUM_REQ-1:0]     lane_ack;
  logic                   busy;

  modport master (
    output req, data_in, out_ready,
    input  gnt, selector, out_data, out_valid, lane_ack, busy
  );

  modport slave (
    input  req, data_in, out_ready,
    output gnt, selector, out_data, out_valid, lane_ack, busy
  );

endinterface

// File: rtl/mux_16_rr_arbiter_mux16.sv
// 16:1 lane selector; lane i occupies i_data[i*BUS +: BUS].
module mux_16 #(
  parameter int BUS = 4
) (
  input  logic [16*BUS-1:0] i_data,
  input  logic [3:0]        i_sel,
  output logic [BUS-1:0]    o_data
);

  assign o_data = i_data[i_sel*BUS +: BUS];

endmodule

// File: rtl/mux_16_rr_arbiter.sv
// Round-robin arbiter sharing one mux_16 among 16 lanes, burst-limited per grant.
//  state | meaning
//  IDLE  | no grant held, waiting for any request
//  GRANT | one lane owns the mux; beats counted toward MAX_BURST
module mux_16_rr_arbiter
  import arb_pkg::*;
#(
  parameter int BUS       = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_16_rr_arbiter_if.slave   bus
);

  localparam int CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;
  logic [CW-1:0]      r_beat_cnt;

  logic               w_busy;
  logic               w_valid;
  logic               w_beat;
  logic               w_release;
  logic               w_any_req;
  logic [SEL_W-1:0]   w_next_ptr;
  logic [SEL_W-1:0]   w_pick_base;
  logic [SEL_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_pick_oh;

  assign w_busy      = (r_state == GRANT);
  assign w_valid     = w_busy & bus.req[r_sel];
  assign w_beat      = w_valid & bus.out_ready;
  assign w_release   = ~bus.req[r_sel] | (w_beat & (r_beat_cnt == LAST_BEAT));
  assign w_any_req   = |bus.req;
  assign w_next_ptr  = r_sel + SEL_W'(1);
  // A release re-arbitrates from the lane after the current owner, not from r_ptr.
  assign w_pick_base = w_busy ? w_next_ptr : r_ptr;
  assign w_pick      = rr_pick(bus.req, w_pick_base);
  assign w_pick_oh   = NUM_REQ'(1) << w_pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state    <= GRANT;
            r_sel      <= w_pick;
            r_gnt      <= w_pick_oh;
            r_beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr <= w_next_ptr;
            if (w_any_req) begin
              r_sel      <= w_pick;
              r_gnt      <= w_pick_oh;
              r_beat_cnt <= '0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
            end
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  mux_16 #(.BUS(BUS)) u_mux (
    .i_data (bus.data_in),
    .i_sel  (r_sel),
    .o_data (bus.out_data)
  );

  assign bus.gnt       = r_gnt;
  assign bus.selector  = r_sel;
  assign bus.out_valid = w_valid;
  assign bus.lane_ack  = r_gnt & {NUM_REQ{w_beat}};
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_mux_16_rr_arbiter.sv
// Scoreboard bench: expected granted lanes are queued with the stimulus and popped per beat.
module tb_mux_16_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   exp_q[$];

  mux_16_rr_arbiter_if #(.BUS(4)) bus();

  mux_16_rr_arbiter #(.BUS(4), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic push_lane(input int lane, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(lane);
  endtask

  task automatic drain_check(input string tag);
    check_val(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Lane data pattern: lane i carries i ^ 9, so lane 3 carries 4'hA.
  function automatic logic [3:0] lane_val(input int lane);
    logic [3:0] l;
    l = 4'(lane);
    return l ^ 4'h9;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_beat_lane", 32'(bus.selector), 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_q.pop_front();
        check_val("beat_sel", 32'(bus.selector), 32'(e));
        check_val("beat_data", 32'(bus.out_data), 32'(lane_val(e)));
        check_val("beat_ack", 32'(bus.lane_ack), 32'(16'(1) << e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus.data_in[i*4 +: 4] = lane_val(i);

    // Reset with every lane requesting.
    bus.req = 16'hFFFF;
    step(3);
    check_val("rst_gnt", 32'(bus.gnt), 32'h0);
    check_val("rst_sel", 32'(bus.selector), 32'h0);
    check_val("rst_valid", 32'(bus.out_valid), 32'h0);
    check_val("rst_busy", 32'(bus.busy), 32'h0);
    check_val("rst_ack", 32'(bus.lane_ack), 32'h0);
    bus.req = 16'h0;
    rst_n = 1'b1;
    step(2);

    // Single lane: one-cycle latency, sole requester re-granted without a bubble.
    bus.req = 16'h0008;
    bus.out_ready = 1'b1;
    push_lane(3, 8);
    step(1);
    check_val("single_gnt", 32'(bus.gnt), 32'h0008);
    check_val("single_sel", 32'(bus.selector), 32'd3);
    check_val("single_data", 32'(bus.out_data), 32'hA);
    step(8);
    check_val("single_regrant_gnt", 32'(bus.gnt), 32'h0008);
    bus.req = 16'h0;
    step(2);
    check_val("single_idle_busy", 32'(bus.busy), 32'h0);
    drain_check("single_leftover");

    // Rotation between lanes 1 and 5.
    do_reset();
    bus.req = 16'h0022;
    push_lane(1, 4); push_lane(5, 4); push_lane(1, 4);
    step(1);
    check_val("rot_first_sel", 32'(bus.selector), 32'd1);
    step(12);
    check_val("rot_next_sel", 32'(bus.selector), 32'd5);
    bus.req = 16'h0;
    step(2);
    drain_check("rot_leftover");

    // Stall mid-burst: grant holds, count resumes from where it stopped.
    do_reset();
    bus.req = 16'h0004;
    push_lane(2, 2);
    step(1);
    check_val("stall_gnt", 32'(bus.gnt), 32'h0004);
    step(2);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      check_val("stall_sel", 32'(bus.selector), 32'd2);
      check_val("stall_valid", 32'(bus.out_valid), 32'h1);
      check_val("stall_ack", 32'(bus.lane_ack), 32'h0);
    end
    bus.out_ready = 1'b1;
    bus.req = 16'h0044;
    push_lane(2, 2); push_lane(6, 4); push_lane(2, 1);
    step(7);
    bus.req = 16'h0;
    step(2);
    drain_check("stall_leftover");

    // Wrap-around: park ptr at 15 via a lane-14 grant, then 15 -> 0 -> 15.
    do_reset();
    bus.out_ready = 1'b0;
    bus.req = 16'h4000;
    step(1);
    check_val("wrap_setup_sel", 32'(bus.selector), 32'd14);
    bus.req = 16'h0;
    step(1);
    check_val("wrap_setup_idle", 32'(bus.busy), 32'h0);
    bus.out_ready = 1'b1;
    bus.req = 16'h8001;
    push_lane(15, 4); push_lane(0, 4); push_lane(15, 1);
    step(1);
    check_val("wrap_gnt", 32'(bus.gnt), 32'h8000);
    step(9);
    bus.req = 16'h0;
    step(2);
    drain_check("wrap_leftover");

    // Reset in the middle of a lane-7 burst clears the grant asynchronously.
    do_reset();
    bus.req = 16'h0080;
    push_lane(7, 2);
    step(1);
    check_val("mid_gnt", 32'(bus.gnt), 32'h0080);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    check_val("mid_rst_busy", 32'(bus.busy), 32'h0);
    check_val("mid_rst_sel", 32'(bus.selector), 32'h0);
    drain_check("mid_pre_leftover");
    step(1);
    rst_n = 1'b1;
    push_lane(7, 2);
    step(1);
    check_val("mid_regrant_sel", 32'(bus.selector), 32'd7);
    step(2);
    bus.req = 16'h0;
    step(2);
    drain_check("mid_leftover");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
